// File: rtl/cv32e40x_aes_pkg.sv
// Shared types and helpers for the protected AES scalar unit's randomness path.
// A random word is the share-B mask in the low byte with the DOM remask bits above it.
package cv32e40x_aes_pkg;

   localparam int AES_RAND_W   = 44;
   localparam int AES_MASK_W   = 8;
   localparam int AES_REMASK_W = 36;

   // Substituted for an all-zero seed, which would lock xorshift at zero forever
   localparam logic [63:0] AES_RNG_ZERO_SEED = 64'h9E3779B97F4A7C15;

   typedef struct packed {
      logic [AES_REMASK_W-1:0] remask;
      logic [AES_MASK_W-1:0]   mask;
   } aes_rand_t;

   typedef enum logic {
      RNG_UNSEEDED = 1'b0,
      RNG_RUN      = 1'b1
   } rng_state_e;

   function automatic logic [63:0] xorshift64_step(input logic [63:0] s);
      logic [63:0] t;
      t = s ^ (s << 13);
      t = t ^ (t >> 7);
      return t ^ (t << 17);
   endfunction

endpackage

// File: rtl/cv32e40x_aes_rand_fifo.sv
// Small synchronous FIFO of random words; the head entry is read straight from storage.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module cv32e40x_aes_rand_fifo
   import cv32e40x_aes_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  logic [AES_RAND_W-1:0] wdata_i,
   input  logic                  pop_i,
   output logic [AES_RAND_W-1:0] rdata_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [PW:0]           count_o
);

   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [AES_RAND_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [PW:0]           cnt_q;
   logic                  do_push, do_pop;

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         // Stale entries stay in storage; they are unreachable once the count is zero
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
      end
   end

endmodule

// File: rtl/cv32e40x_aes_rng_buffer.sv
// Xorshift64 randomness source for the masked AES unit, buffered so a fresh word
// is ready every issue cycle; also tracks words drawn per seed and starvation.
module cv32e40x_aes_rng_buffer
   import cv32e40x_aes_pkg::*;
#(
   parameter int          DEPTH           = 4,
   parameter logic [63:0] SEED_DEFAULT    = AES_RNG_ZERO_SEED,
   parameter bit          REQUIRE_SEED    = 1'b0,
   parameter int          RESEED_INTERVAL = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_n,
   input  logic                    seed_valid_i,
   input  logic [63:0]             seed_i,
   output logic                    rand_valid_o,
   input  logic                    rand_ready_i,
   output logic [AES_MASK_W-1:0]   shareB_mask_o,
   output logic [AES_REMASK_W-1:0] randombits_o,
   output logic                    reseed_req_o,
   output logic [15:0]             starve_cnt_o
);

   localparam int          PW         = $clog2(DEPTH);
   localparam logic [15:0] RESEED_CNT = 16'(RESEED_INTERVAL);

   rng_state_e  state_q;
   logic [63:0] gen_q, gen_next;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic [15:0] starve_q;
   logic        reseed_q;

   aes_rand_t       head;
   logic [PW:0]     fifo_cnt;
   logic            fifo_full, fifo_empty;
   logic            push, pop;

   assign gen_next     = xorshift64_step(gen_q);
   assign rand_valid_o = ~fifo_empty;
   assign pop          = rand_valid_o & rand_ready_i;
   assign push         = (state_q == RNG_RUN) & ~seed_valid_i & (~fifo_full | pop);

   assign shareB_mask_o = head.mask;
   assign randombits_o  = head.remask;
   assign reseed_req_o  = reseed_q;
   assign starve_cnt_o  = starve_q;

   cv32e40x_aes_rand_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .flush_i (seed_valid_i),
      .push_i  (push),
      .wdata_i (gen_next[AES_RAND_W-1:0]),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   // A seed restarts the per-seed word count even when a pop lands in the same cycle
   always_comb begin
      word_cnt_d = word_cnt_q;
      if (seed_valid_i)                   word_cnt_d = '0;
      else if (pop && word_cnt_q != '1)   word_cnt_d = word_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= REQUIRE_SEED ? RNG_UNSEEDED : RNG_RUN;
         gen_q      <= SEED_DEFAULT;
         word_cnt_q <= '0;
         reseed_q   <= 1'b0;
         starve_q   <= '0;
      end else begin
         word_cnt_q <= word_cnt_d;
         reseed_q   <= (word_cnt_d >= RESEED_CNT);
         if (rand_ready_i && fifo_cnt == '0 && starve_q != '1)
            starve_q <= starve_q + 16'd1;
         if (seed_valid_i) begin
            state_q <= RNG_RUN;
            gen_q   <= (seed_i == '0) ? SEED_DEFAULT : seed_i;
         end else if (push) begin
            gen_q <= gen_next;
         end
      end
   end

endmodule

// File: doc/cv32e40x_aes_rng_buffer.md
Name: cv32e40x_aes_rng_buffer

Overview:
- Upstream randomness supplier for the protected AES scalar unit.
- Each accepted word carries 44 fresh bits: an 8-bit share-B mask plus 36 remask bits for the DOM S-box.
- A seeded xorshift64 generator refills a small FIFO so one word is available per AES issue cycle. The FIFO also absorbs back-pressure from the AES input register.
- Counts words drawn since the last seed, raises a reseed request, and counts starvation cycles.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SEED_DEFAULT, 64'h9E3779B97F4A7C15, generator state after reset when REQUIRE_SEED=0.
- REQUIRE_SEED, 0, 1 = no generation until the first seed_valid_i.
- RESEED_INTERVAL, 1024, words consumed before reseed_req_o asserts; range 1..65535.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seed_valid_i  in  1  one-cycle pulse: load seed_i and flush the FIFO.
- seed_i  in  64  new generator state.
- rand_valid_o  out  1  FIFO head valid.
- rand_ready_i  in  1  consumer accepts the head; connect to the AES ready_i.
- shareB_mask_o  out  8  head word bits [7:0].
- randombits_o  out  36  head word bits [43:8].
- reseed_req_o  out  1  words since seed >= RESEED_INTERVAL.
- starve_cnt_o  out  16  saturating count of cycles with rand_ready_i=1 and rand_valid_o=0.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_n.
- Values in reset:
  - FIFO empty, rand_valid_o=0, data outputs 0.
  - reseed_req_o=0, starve_cnt_o=0, word counter=0.
  - Generator state = SEED_DEFAULT.
  - FSM in RUN if REQUIRE_SEED=0, otherwise UNSEEDED.
- FSM:
  - UNSEEDED: no generation, FIFO stays empty. Goes to RUN on seed_valid_i.
  - RUN: stays in RUN; there is no exit except reset.
- Generator step:
  - t = s ^ (s<<13); t = t ^ (t>>7); next = t ^ (t<<17), all 64-bit.
  - Push word = next[43:0]. State becomes next on every push.
- Push rule: a push occurs in a cycle with state RUN, no seed_valid_i, and (count < DEPTH or pop this cycle). One push per cycle max.
- Pop rule: pop = rand_valid_o & rand_ready_i. The head advances at the clock edge.
- Simultaneous push and pop: count is unchanged. A full FIFO with a pop still pushes, so throughput is one word per cycle.
- Output timing: outputs are driven from the FIFO head register, not from the generator.
  - Latency from a push cycle to rand_valid_o high is 1 cycle.
  - A write into an empty FIFO is visible the next cycle.
- Seed load (seed_valid_i in cycle N):
  - State := seed_i, or SEED_DEFAULT if seed_i==0, because zero is a lock-up state.
  - FIFO flushed (count=0), word counter=0, reseed_req_o=0, all at the N edge.
  - No push in cycle N. The first push is in N+1, so rand_valid_o=1 in N+2.
  - If a pop coincides with the seed in cycle N, the pop completes: the consumer keeps that word, then the flush happens.
  - starve_cnt_o is not cleared by a seed.
- Word counter: 16-bit, increments per pop, saturates at 65535. reseed_req_o is a registered compare: it is 1 in the cycle after the counter reaches RESEED_INTERVAL.
  - Generation continues while reseed_req_o=1; the request is advisory only.
- starve_cnt_o: increments in any cycle with rand_ready_i=1 and rand_valid_o=0, including in UNSEEDED. It saturates at 16'hFFFF.
- Pointers: log2(DEPTH) bits wrap naturally. Count is log2(DEPTH)+1 bits.
- Reset mid-operation: everything returns to reset values asynchronously. Words in flight are lost, and the sequence restarts from SEED_DEFAULT.
- Security: no bit of generator state other than the pushed word is exposed. Consumed entries are not cleared (acceptable, since the consumer already holds them).

Decomposition:
- Shared package cv32e40x_aes_pkg holds:
  - AES_RAND_W=44, AES_MASK_W=8, AES_REMASK_W=36.
  - Typedef aes_rand_t (struct: remask[35:0], mask[7:0]).
  - The xorshift64 step function.
  - The zero-seed substitute constant.
- One sub-module: cv32e40x_aes_rand_fifo (generic DEPTH x aes_rand_t sync FIFO with full/empty/count; async active-low reset). The generator, FSM and counters stay in the top module.

Test Plan:
- Reset with REQUIRE_SEED=0, seed pulse with seed_i=64'h1 at cycle N, rand_ready_i=0 -> rand_valid_o=1 at N+2 with shareB_mask_o=8'h41 and randombits_o=36'h000408220 (next=64'h40822041). The FIFO fills to DEPTH=4, then pushes stop.
- Full FIFO with rand_ready_i held 1 for 20 cycles -> 20 consecutive words with valid never dropping. The words match the reference-model xorshift sequence in order, and starve_cnt_o stays 0.
- REQUIRE_SEED=1 with rand_ready_i=1 for 10 cycles before the seed -> rand_valid_o=0 and starve_cnt_o=10. After seeding, valid rises two cycles later.
- Seed pulse coincident with a pop while 3 entries are stored -> the popped word is accepted. The next cycle shows rand_valid_o=0, then the new-seed sequence appears; no stale words follow.
- seed_i=0 -> the output sequence equals the one for seed SEED_DEFAULT.
- RESEED_INTERVAL=8, pop 8 words -> reseed_req_o=1 in the cycle after the 8th pop and stays high. A seed pulse clears it the next cycle.
